// File: rtl/mfb_frame_mask_gen.sv
// mfb_frame_mask_gen: credit-based per-region pass/drop mask generator for the
// MFB frame masker. It watches the same MFB word the masker sees and decides,
// per frame, whether the frame passes (mask=1) or is dropped (mask=0).
// Each passed frame consumes one credit, and the downstream buffer returns
// credits as it drains frames.
// Optional statistics counters are enabled by defining MFB_MASK_GEN_STATS_EN.
module mfb_frame_mask_gen #(
   parameter int REGIONS     = 4,
   parameter int REGION_SIZE = 8,
   parameter int BLOCK_SIZE  = 8,
   parameter int MAX_CREDITS = 64,
   parameter int RET_WIDTH   = 4
) (
   input  logic                                              CLK,
   input  logic                                              RESET_N,
   input  logic [REGIONS-1:0]                                RX_SOF,
   input  logic [REGIONS-1:0]                                RX_EOF,
   input  logic [REGIONS*$clog2(REGION_SIZE)-1:0]            RX_SOF_POS,
   input  logic [REGIONS*$clog2(REGION_SIZE*BLOCK_SIZE)-1:0] RX_EOF_POS,
   input  logic                                              RX_SRC_RDY,
   input  logic                                              RX_DST_RDY,
   input  logic                                              RET_VLD,
   input  logic [RET_WIDTH-1:0]                              RET_CNT,
   output logic [REGIONS-1:0]                                TX_MASK,
   output logic [$clog2(MAX_CREDITS+1)-1:0]                  CREDITS,
   output logic                                              RET_OVF
`ifdef MFB_MASK_GEN_STATS_EN
   ,
   input  logic                                              STAT_CLR,
   output logic [31:0]                                       STAT_PASS,
   output logic [31:0]                                       STAT_DROP
`endif
);

   localparam int SPW = $clog2(REGION_SIZE);
   localparam int EPW = $clog2(REGION_SIZE*BLOCK_SIZE);
   localparam int CW  = $clog2(MAX_CREDITS+1);
   localparam int GW  = $clog2(REGIONS+1);
   localparam int SW  = ((CW > RET_WIDTH) ? CW : RET_WIDTH) + 1;

   logic [CW-1:0]      credits;
   logic               ret_ovf;
   logic               in_prog;
   logic               prog_dec;
   logic               xfer;
   logic [REGIONS-1:0] mask;
   logic [GW-1:0]      grants;
   logic               run;
   logic               dec;
   logic [SPW-1:0]     sof_pos;
   logic [EPW-1:0]     eof_pos;
   logic               eof_first;
   logic [SW-1:0]      cred_sum;

   // Clamp the widened credit sum back into the counter range.
   function automatic logic [CW-1:0] clamp_credits(input logic [SW-1:0] v);
      if (v > SW'(MAX_CREDITS))
         return CW'(MAX_CREDITS);
      return v[CW-1:0];
   endfunction

   assign xfer = RX_SRC_RDY & RX_DST_RDY;

   // Walk the regions from 0 upward: new frames take credits in order, and the
   // frame state carries from region to region and out to the next word.
   always_comb begin
      mask      = '0;
      grants    = '0;
      run       = in_prog;
      dec       = prog_dec;
      sof_pos   = '0;
      eof_pos   = '0;
      eof_first = 1'b0;
      for (int i = 0; i < REGIONS; i++) begin
         sof_pos   = RX_SOF_POS[i*SPW +: SPW];
         eof_pos   = RX_EOF_POS[i*EPW +: EPW];
         // An EOF that lies before the SOF block closes the previous frame.
         eof_first = RX_EOF[i] && (int'(eof_pos) < int'(sof_pos) * BLOCK_SIZE);
         if (RX_SOF[i]) begin
            // Credits returned this cycle are not visible here.
            dec = (int'(credits) > int'(grants));
            if (dec)
               grants = grants + GW'(1);
            mask[i] = dec;
            run     = !RX_EOF[i] || eof_first;
         end else begin
            mask[i] = run & dec;
            if (RX_EOF[i])
               run = 1'b0;
         end
      end
   end

   // Net credit change for this cycle, one bit wider than either operand.
   always_comb begin
      cred_sum = SW'(credits) - (xfer ? SW'(grants) : '0) + (RET_VLD ? SW'(RET_CNT) : '0);
   end

   // Credit counter and sticky overflow; returns apply every cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         credits <= CW'(MAX_CREDITS);
         ret_ovf <= 1'b0;
      end else begin
         credits <= clamp_credits(cred_sum);
         if (cred_sum > SW'(MAX_CREDITS))
            ret_ovf <= 1'b1;
      end
   end

   // Frame-in-progress state after the highest region, kept on transfers only.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         in_prog  <= 1'b0;
         prog_dec <= 1'b0;
      end else if (xfer) begin
         in_prog  <= run;
         prog_dec <= dec;
      end
   end

   assign TX_MASK = mask;
   assign CREDITS = credits;
   assign RET_OVF = ret_ovf;

`ifdef MFB_MASK_GEN_STATS_EN
   logic [GW-1:0] drops;
   logic [31:0]   stat_pass;
   logic [31:0]   stat_drop;

   assign drops = GW'($countones(RX_SOF)) - grants;

   // Saturating accumulate for the 32-bit frame counters.
   function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [GW-1:0] inc);
      logic [32:0] s;
      s = {1'b0, acc} + 33'(inc);
      return s[32] ? '1 : s[31:0];
   endfunction

   // Pass/drop counters; a clear coinciding with a transfer loads that word's count.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         stat_pass <= '0;
         stat_drop <= '0;
      end else if (STAT_CLR) begin
         stat_pass <= xfer ? 32'(grants) : '0;
         stat_drop <= xfer ? 32'(drops) : '0;
      end else if (xfer) begin
         stat_pass <= sat_add(stat_pass, grants);
         stat_drop <= sat_add(stat_drop, drops);
      end
   end

   assign STAT_PASS = stat_pass;
   assign STAT_DROP = stat_drop;
`endif

endmodule
